// File: rtl/mem_burst_pkg.sv
// rtl/mem_burst_pkg.sv - shared types and defaults for the mem_64kib burst master
package mem_burst_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_BURST_DEF = 16;
  localparam int LEN_W_DEF     = $clog2(MAX_BURST_DEF + 1);

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    MEM,
    ROUT
  } state_e;

  typedef struct packed {
    logic                    write;
    logic [ADDR_W_DEF-1:0]   addr;
    logic [LEN_W_DEF-1:0]    len;
    logic [DATA_W_DEF/8-1:0] be;
  } burst_cmd_t;

endpackage

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst master issuing one held word access per beat to mem_64kib
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter  int ADDR_W    = ADDR_W_DEF,
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int MAX_BURST = MAX_BURST_DEF,
  localparam int LEN_W     = $clog2(MAX_BURST + 1),
  localparam int BE_W      = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LEN_W-1:0]  req_len_i,
  input  logic [BE_W-1:0]   req_be_i,
  input  logic              wdata_valid_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              wdata_ready_o,
  output logic              rdata_valid_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              rdata_ready_i,
  output logic              mem_read_en_o,
  output logic [BE_W-1:0]   mem_write_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_d_o,
  input  logic [DATA_W-1:0] mem_d_i,
  input  logic              mem_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mem_re;
  logic [BE_W-1:0]     r_mem_we;
  logic                r_done;
  logic                r_err;

  logic                w_cmd_hs;
  logic                w_cmd_legal;
  logic                w_last;
  logic                w_beat_done;
  logic                w_nxt_write;
  logic [BE_W-1:0]     w_nxt_be;

  assign w_cmd_hs    = (r_state == IDLE) && req_valid_i;
  assign w_cmd_legal = (req_addr_i[1:0] == 2'b00) &&
                       (req_len_i != '0) &&
                       (int'(req_len_i) <= MAX_BURST) &&
                       !(req_write_i && (req_be_i == '0));
  assign w_last      = (r_len == LEN_W'(1));

  // The command fields are not latched until the accept edge, so entry into MEM looks at the inputs.
  assign w_nxt_write = (r_state == IDLE) ? req_write_i : r_write;
  assign w_nxt_be    = (r_state == IDLE) ? req_be_i    : r_be;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid_i && w_cmd_legal) begin
          w_state_nxt = req_write_i ? WDATA : MEM;
        end
      end
      WDATA: begin
        if (wdata_valid_i) begin
          w_state_nxt = MEM;
        end
      end
      MEM: begin
        if (mem_ready_i) begin
          if (r_write) begin
            w_beat_done = 1'b1;
            w_state_nxt = w_last ? IDLE : WDATA;
          end else begin
            w_state_nxt = ROUT;
          end
        end
      end
      ROUT: begin
        if (rdata_ready_i) begin
          w_beat_done = 1'b1;
          w_state_nxt = w_last ? IDLE : MEM;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_len    <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_mem_re <= 1'b0;
      r_mem_we <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_beat_done && w_last;
      r_err  <= w_cmd_hs && !w_cmd_legal;
      if (w_cmd_hs) begin
        r_write <= req_write_i;
        r_addr  <= req_addr_i;
        r_len   <= req_len_i;
        r_be    <= req_be_i;
      end
      if ((r_state == WDATA) && wdata_valid_i) begin
        r_wdata <= wdata_i;
      end
      if ((r_state == MEM) && mem_ready_i && !r_write) begin
        r_rdata <= mem_d_i;
      end
      if (w_beat_done) begin
        r_addr <= r_addr + ADDR_W'(4);
        r_len  <= r_len - LEN_W'(1);
      end
      // Every beat leaves MEM for at least a cycle, so the enables always drop between accesses.
      r_mem_re <= (w_state_nxt == MEM) && !w_nxt_write;
      r_mem_we <= ((w_state_nxt == MEM) && w_nxt_write) ? w_nxt_be : '0;
    end
  end

  assign req_ready_o    = (r_state == IDLE);
  assign wdata_ready_o  = (r_state == WDATA);
  assign rdata_valid_o  = (r_state == ROUT);
  assign rdata_o        = r_rdata;
  assign mem_read_en_o  = r_mem_re;
  assign mem_write_en_o = r_mem_we;
  assign mem_addr_o     = r_addr;
  assign mem_d_o        = r_wdata;
  assign busy_o         = (r_state != IDLE);
  assign done_o         = r_done;
  assign err_o          = r_err;

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
Burst master that sits directly upstream of mem_64kib and is the only block driving its read_en/write_en/addr/d ports. It accepts a burst command (start address, length, direction, byte enables) over a valid/ready handshake, then issues one word access per beat at incrementing word addresses. Write data is consumed from a valid/ready stream and read data is returned on one. Each access is held until the memory's ready_o completes it.

Parameters:
ADDR_W, 32, address width (byte address)
DATA_W, 32, data word width; byte enables are DATA_W/8
MAX_BURST, 16, maximum beats per burst; LEN_W = $clog2(MAX_BURST+1)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  burst command valid
req_ready_o  out  1  command accepted when valid&&ready
req_write_i  in  1  1 = write burst, 0 = read burst
req_addr_i  in  ADDR_W  start byte address
req_len_i  in  LEN_W  beat count, legal range 1..MAX_BURST
req_be_i  in  DATA_W/8  byte enables applied to every write beat
wdata_valid_i  in  1  write beat valid
wdata_i  in  DATA_W  write beat data
wdata_ready_o  out  1  write beat accepted when valid&&ready
rdata_valid_o  out  1  read beat valid
rdata_o  out  DATA_W  read beat data
rdata_ready_i  in  1  read beat consumed when valid&&ready
mem_read_en_o  out  1  to mem_64kib read_en_i
mem_write_en_o  out  DATA_W/8  to mem_64kib write_en_i
mem_addr_o  out  ADDR_W  to mem_64kib addr_i
mem_d_o  out  DATA_W  to mem_64kib d_i
mem_d_i  in  DATA_W  from mem_64kib d_o
mem_ready_i  in  1  from mem_64kib ready_o; completes the current access
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle pulse when the final beat completes
err_o  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 except req_ready_o = 1. Outputs go 0 immediately on assert. Any in-flight burst is abandoned and no partial beat is retried.
- States: IDLE, WDATA, MEM, ROUT.
- IDLE: req_ready_o = 1. On handshake the block latches addr, len, be and write into registers, then validates:
  - reject if req_addr_i[1:0] != 0, req_len_i == 0, req_len_i > MAX_BURST, or (write and req_be_i == 0);
  - on reject: err_o pulses the next cycle, state stays IDLE, no memory access occurs;
  - if valid: write goes to WDATA, read goes to MEM.
- WDATA: wdata_ready_o = 1. On beat handshake, wdata_i is latched into mem_d_o and the state goes to MEM.
- MEM:
  - mem_addr_o = current address. mem_write_en_o = be (write) or 0; mem_read_en_o = !write.
  - Enables hold steady until the first cycle mem_ready_i = 1. That cycle completes the access: read captures mem_d_i into rdata_o and goes to ROUT; write decrements the beat count.
  - mem_ready_i is ignored in every state except MEM.
  - Minimum one cycle in MEM; the enables are registered outputs.
- ROUT: rdata_valid_o = 1 and rdata_o holds stable until rdata_ready_i. On handshake the beat count decrements.
- After each completed beat: address += 4 (modulo 2^ADDR_W, wraps silently). If beats remain, go to WDATA (write) or MEM (read). Otherwise done_o pulses and the state returns to IDLE.
- Enables deassert for at least one cycle between consecutive beats. No new command is accepted until IDLE.
- busy_o = (state != IDLE).

Decomposition:
- Package mem_burst_pkg: state enum state_e {IDLE, WDATA, MEM, ROUT}, MAX_BURST default, and a burst command struct {write, addr, len, be}.
- Single module, no sub-modules. The FSM plus a beat counter and an address register fit in one file.

Test Plan:
- Single write: addr=0x100, len=1, be=4'b1111, wdata=0xDEADBEEF; memory returns ready 1 cycle after enable -> one access with mem_write_en_o=1111 and mem_addr_o=0x100, then done_o pulse.
- Read burst: addr=0x200, len=4; memory preloaded with 0xA0..0xA3 -> mem_addr_o sequence 0x200/204/208/20C, rdata_o sequence 0xA0..0xA3, then done_o.
- Backpressure: read len=2 with rdata_ready_i low for 5 cycles -> rdata_o stable and no second memory access until the handshake; partial write with be=4'b0011 -> only bytes 0-1 change.
- Slow memory: mem_ready_i delayed 3 cycles per access -> enables and address held steady across the wait; write burst len=3 completes exactly 3 accesses.
- Rejects: addr=0x102, then len=0, then write with be=0 -> err_o pulses for each, no enable asserted, busy_o stays 0. Wrap case: addr=0xFFFFFFFC, len=2 -> second beat addr=0x00000000.
- Reset mid-burst: assert rst_ni low during MEM of beat 2 of 4 -> enables drop immediately (same cycle), busy_o=0, req_ready_o=1 after release.
